// File: rtl/sata_link_pkg.sv
// Shared types and constants for the SATA link-layer transmit arbiter.
package sata_link_pkg;

   // Arbiter ownership states: idle, or streaming a frame from requester 0/1.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   // Default tuser layout is {drop, err, keep[3:0], sop, eop}.
   localparam int USER_W_DEF  = 8;
   localparam int SOP_BIT_DEF = 1;
   localparam int EOP_BIT_DEF = 0;

   // Width of the completed-frame counters.
   localparam int CNT_W = 16;

   // One-hot owner code presented on the grant port for a given state.
   function automatic logic [1:0] state_to_grant(input arb_state_e s);
      logic [1:0] g;
      case (s)
         OWN0:    g = 2'b01;
         OWN1:    g = 2'b10;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/sata_link_tx_arb.sv
// Two-requester frame arbiter in front of the SATA link egress buffer.
// Requester 0 carries transport data, requester 1 carries control FISes.
// A grant is taken only on a sop beat and held until the eop handshake;
// stray non-sop beats seen while idle are swallowed.
// Optional statistics (frame counters, orphan pulse): define SATA_TX_ARB_STAT_EN.
module sata_link_tx_arb
   import sata_link_pkg::*;
#(
   parameter int USER_W  = USER_W_DEF,
   parameter int SOP_BIT = SOP_BIT_DEF,
   parameter int EOP_BIT = EOP_BIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       s0_aixs_tdata,
   input  logic [USER_W-1:0] s0_aixs_tuser,
   input  logic              s0_aixs_tvalid,
   output logic              s0_aixs_tready,
   input  logic [31:0]       s1_aixs_tdata,
   input  logic [USER_W-1:0] s1_aixs_tuser,
   input  logic              s1_aixs_tvalid,
   output logic              s1_aixs_tready,
   output logic [31:0]       m_aixs_tdata,
   output logic [USER_W-1:0] m_aixs_tuser,
   output logic              m_aixs_tvalid,
   input  logic              m_aixs_tready,
   input  logic              buffer_full,
   output logic [1:0]        grant,
   output logic              orphan_err,
   output logic [CNT_W-1:0]  frame_cnt0,
   output logic [CNT_W-1:0]  frame_cnt1
);

   arb_state_e state_q, state_d;
   logic       last_grant_q, last_grant_d;
   logic [1:0] grant_q, grant_d;

   logic s0_sop, s1_sop, s0_eop, s1_eop;
   logic elig0, elig1;
   logic eop_hs0, eop_hs1;

   assign s0_sop = s0_aixs_tuser[SOP_BIT];
   assign s1_sop = s1_aixs_tuser[SOP_BIT];
   assign s0_eop = s0_aixs_tuser[EOP_BIT];
   assign s1_eop = s1_aixs_tuser[EOP_BIT];

   // A new frame may only start when the egress buffer has room for it.
   assign elig0 = s0_aixs_tvalid & s0_sop & ~buffer_full;
   assign elig1 = s1_aixs_tvalid & s1_sop & ~buffer_full;

   assign eop_hs0 = (state_q == OWN0) & s0_aixs_tvalid & m_aixs_tready & s0_eop;
   assign eop_hs1 = (state_q == OWN1) & s1_aixs_tvalid & m_aixs_tready & s1_eop;

   // Next-state: round-robin on ties, release the grant after the eop handshake.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (elig0 && elig1) begin
               state_d = last_grant_q ? OWN0 : OWN1;
            end else if (elig0) begin
               state_d = OWN0;
            end else if (elig1) begin
               state_d = OWN1;
            end
         end
         OWN0: begin
            if (eop_hs0) begin
               state_d = IDLE;
            end
         end
         OWN1: begin
            if (eop_hs1) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_q == IDLE && state_d == OWN0) begin
         last_grant_d = 1'b0;
      end else if (state_q == IDLE && state_d == OWN1) begin
         last_grant_d = 1'b1;
      end
      grant_d = state_to_grant(state_d);
   end

   // FSM state, round-robin pointer and registered grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 2'b00;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
      end
   end

   assign grant = grant_q;

   // Datapath mux; idle readies are gated by rst_n so they drop during reset.
   always_comb begin
      m_aixs_tdata   = '0;
      m_aixs_tuser   = '0;
      m_aixs_tvalid  = 1'b0;
      s0_aixs_tready = 1'b0;
      s1_aixs_tready = 1'b0;
      case (state_q)
         IDLE: begin
            s0_aixs_tready = rst_n & s0_aixs_tvalid & ~s0_sop;
            s1_aixs_tready = rst_n & s1_aixs_tvalid & ~s1_sop;
         end
         OWN0: begin
            m_aixs_tdata   = s0_aixs_tdata;
            m_aixs_tuser   = s0_aixs_tuser;
            m_aixs_tvalid  = s0_aixs_tvalid;
            s0_aixs_tready = m_aixs_tready;
         end
         OWN1: begin
            m_aixs_tdata   = s1_aixs_tdata;
            m_aixs_tuser   = s1_aixs_tuser;
            m_aixs_tvalid  = s1_aixs_tvalid;
            s1_aixs_tready = m_aixs_tready;
         end
         default: begin
            m_aixs_tvalid  = 1'b0;
         end
      endcase
   end

`ifdef SATA_TX_ARB_STAT_EN
   logic [CNT_W-1:0] cnt0_q, cnt1_q;
   logic [CNT_W-1:0] cnt0_d, cnt1_d;

   // Counter increment on each eop handshake; natural wrap at full scale.
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (eop_hs0) begin
         cnt0_d = cnt0_q + 1'b1;
      end
      if (eop_hs1) begin
         cnt1_d = cnt1_q + 1'b1;
      end
   end

   // Completed-frame counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign frame_cnt0 = cnt0_q;
   assign frame_cnt1 = cnt1_q;
   // Pulses in the same cycle the orphan beat is swallowed.
   assign orphan_err = rst_n & (state_q == IDLE) &
                       ((s0_aixs_tvalid & ~s0_sop) | (s1_aixs_tvalid & ~s1_sop));
`else
   assign frame_cnt0 = '0;
   assign frame_cnt1 = '0;
   assign orphan_err = 1'b0;
`endif

endmodule
